// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, scan counters, a look-ahead
// fetch position and combinational sync/blank/strobe decode.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int PIX_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LEAD     = 0,
  parameter int CW       = 10
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          en,
  output logic          HS,
  output logic          VS,
  output logic          blank,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start,
  output logic [CW-1:0] fetch_row,
  output logic [CW-1:0] fetch_col,
  output logic          fetch_valid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] LEAD_C   = CW'(LEAD);
  // Sync window bounds carry one extra bit: the end may equal the total.
  localparam logic [CW:0]   HS_BEG   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_BEG   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [DW-1:0] div;
  logic [CW-1:0] h, v, fh, fv;
  logic          run, h_wrap, fh_wrap, pix0, in_hs, in_vs;

  // Outputs are gated by reset as well as en so they read idle while reset is held.
  assign run      = en & reset_n;
  assign pix_tick = run & (div == DIV_LAST);
  assign h_wrap   = (h == H_LAST);
  assign fh_wrap  = (fh == H_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
      fh  <= LEAD_C;
      fv  <= '0;
    end else if (!en) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
      fh  <= LEAD_C;
      fv  <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      if (pix_tick) begin
        h  <= h_wrap ? '0 : h + 1'b1;
        fh <= fh_wrap ? '0 : fh + 1'b1;
        if (h_wrap)  v  <= (v == V_LAST)  ? '0 : v + 1'b1;
        if (fh_wrap) fv <= (fv == V_LAST) ? '0 : fv + 1'b1;
      end
    end
  end

  assign in_hs = ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
  assign in_vs = ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
  assign pix0  = run & (div == '0);

  assign HS           = (run && in_hs) ? HS_ON : ~HS_ON;
  assign VS           = (run && in_vs) ? VS_ON : ~VS_ON;
  assign blank        = ~run | (h >= H_ACT) | (v >= V_ACT);
  assign row          = v;
  assign col          = h;
  assign line_start   = pix0 & (h == '0);
  assign frame_start  = line_start & (v == '0);
  assign vblank_start = line_start & (v == V_ACT);
  assign fetch_row    = fv;
  assign fetch_col    = fh;
  assign fetch_valid  = run & (fh < H_ACT) & (fv < V_ACT);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an
// arithmetic raster model, plus directed checks of the documented timing points.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, pd, hpol, vpol, lead;
  } cfg_t;

  typedef struct packed {
    logic hs, vs, blank, pix_tick, ls, fs, vbs, fvalid;
    logic [11:0] row, col, frow, fcol;
  } vis_t;

  localparam int W = $bits(vis_t);

  localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 29, 2, 0, 0, 0};
  localparam cfg_t CFG_B = '{8, 2, 3, 2, 6, 1, 2, 1, 3, 0, 1, 4};
  localparam cfg_t CFG_C = '{640, 16, 96, 48, 480, 10, 2, 29, 1, 1, 1, 4};

  // ---------------- clock / reset / dut ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, hs_a, vs_a, blank_a, pt_a, ls_a, fs_a, vbs_a, fv_a;
  logic [9:0] row_a, col_a, frow_a, fcol_a;
  logic       rst_b, en_b, hs_b, vs_b, blank_b, pt_b, ls_b, fs_b, vbs_b, fv_b;
  logic [4:0] row_b, col_b, frow_b, fcol_b;
  logic       rst_c, en_c, hs_c, vs_c, blank_c, pt_c, ls_c, fs_c, vbs_c, fv_c;
  logic [9:0] row_c, col_c, frow_c, fcol_c;

  vga_timing_gen u_a (
    .CLOCK_50(clk), .reset_n(rst_a), .en(en_a), .HS(hs_a), .VS(vs_a), .blank(blank_a),
    .row(row_a), .col(col_a), .pix_tick(pt_a), .line_start(ls_a), .frame_start(fs_a),
    .vblank_start(vbs_a), .fetch_row(frow_a), .fetch_col(fcol_a), .fetch_valid(fv_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .PIX_DIV(3), .HS_POL(0), .VS_POL(1), .LEAD(4), .CW(5)
  ) u_b (
    .CLOCK_50(clk), .reset_n(rst_b), .en(en_b), .HS(hs_b), .VS(vs_b), .blank(blank_b),
    .row(row_b), .col(col_b), .pix_tick(pt_b), .line_start(ls_b), .frame_start(fs_b),
    .vblank_start(vbs_b), .fetch_row(frow_b), .fetch_col(fcol_b), .fetch_valid(fv_b)
  );

  vga_timing_gen #(.PIX_DIV(1), .HS_POL(1), .VS_POL(1), .LEAD(4)) u_c (
    .CLOCK_50(clk), .reset_n(rst_c), .en(en_c), .HS(hs_c), .VS(vs_c), .blank(blank_c),
    .row(row_c), .col(col_c), .pix_tick(pt_c), .line_start(ls_c), .frame_start(fs_c),
    .vblank_start(vbs_c), .fetch_row(frow_c), .fetch_col(fcol_c), .fetch_valid(fv_c)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vis_t mk(input logic hs, vs, blank, pt, ls, fs, vbs, fv,
                              input logic [11:0] r, c, fr, fc);
    vis_t o;
    o = '{hs: hs, vs: vs, blank: blank, pix_tick: pt, ls: ls, fs: fs, vbs: vbs,
          fvalid: fv, row: r, col: c, frow: fr, fcol: fc};
    return o;
  endfunction

  // Reference: t counts enabled cycles since the raster origin; everything else is
  // plain division/modulo of that count by the line and frame sizes.
  function automatic vis_t model(input cfg_t c, input int t, input logic en, input logic rst);
    int ht, vt, p, d, h, v, fp, fh, fv;
    logic run, hp, vp, ls;
    vis_t e;
    ht  = c.ha + c.hfp + c.hs + c.hbp;
    vt  = c.va + c.vfp + c.vs + c.vbp;
    run = en & rst;
    hp  = c.hpol[0];
    vp  = c.vpol[0];
    p   = t / c.pd;
    d   = t % c.pd;
    h   = p % ht;
    v   = (p / ht) % vt;
    fp  = p + c.lead;
    fh  = fp % ht;
    fv  = (fp / ht) % vt;
    ls  = run && d == 0 && h == 0;
    e.hs       = (run && h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? hp : ~hp;
    e.vs       = (run && v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? vp : ~vp;
    e.blank    = !run || h >= c.ha || v >= c.va;
    e.pix_tick = run && d == c.pd - 1;
    e.ls       = ls;
    e.fs       = ls && v == 0;
    e.vbs      = ls && v == c.va;
    e.fvalid   = run && fh < c.ha && fv < c.va;
    e.row      = 12'(v);
    e.col      = 12'(h);
    e.frow     = 12'(fv);
    e.fcol     = 12'(fh);
    return e;
  endfunction

  int t_a, t_b, t_c;
  always @(posedge clk or negedge rst_a) if (!rst_a) t_a = 0; else t_a = en_a ? t_a + 1 : 0;
  always @(posedge clk or negedge rst_b) if (!rst_b) t_b = 0; else t_b = en_b ? t_b + 1 : 0;
  always @(posedge clk or negedge rst_c) if (!rst_c) t_c = 0; else t_c = en_c ? t_c + 1 : 0;

  vis_t obs_a, obs_b, obs_c;
  always_comb obs_a = mk(hs_a, vs_a, blank_a, pt_a, ls_a, fs_a, vbs_a, fv_a,
                         12'(row_a), 12'(col_a), 12'(frow_a), 12'(fcol_a));
  always_comb obs_b = mk(hs_b, vs_b, blank_b, pt_b, ls_b, fs_b, vbs_b, fv_b,
                         12'(row_b), 12'(col_b), 12'(frow_b), 12'(fcol_b));
  always_comb obs_c = mk(hs_c, vs_c, blank_c, pt_c, ls_c, fs_c, vbs_c, fv_c,
                         12'(row_c), 12'(col_c), 12'(frow_c), 12'(fcol_c));

  // Scoreboard: expected vectors queued in instance order, popped against observations.
  logic [W-1:0] exp_q[$];
  always @(negedge clk) begin
    exp_q.push_back(model(CFG_A, t_a, en_a, rst_a));
    exp_q.push_back(model(CFG_B, t_b, en_b, rst_b));
    exp_q.push_back(model(CFG_C, t_c, en_c, rst_c));
    check("a_cycle", 64'(obs_a), 64'(exp_q.pop_front()));
    check("b_cycle", 64'(obs_b), 64'(exp_q.pop_front()));
    check("c_cycle", 64'(obs_c), 64'(exp_q.pop_front()));
  end

  // ---------------- driver tasks for instance B ----------------
  task automatic wait_pos_b(input int r, input int c, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(row_b == 5'(r) && col_b == 5'(c)) && n < 2000);
    if (n >= 2000) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fs_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_b && n < 1000);
  endtask

  bit b_done = 0;

  initial begin : drive_b
    int per, r, len;
    rst_b = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk);
    #1 en_b = 1'b1;

    // Look-ahead fetch across line, active-area and frame boundaries.
    wait_pos_b(2, 11, "b_pos_2_11");
    check("b_fetch_row_int", frow_b, 3);
    check("b_fetch_col_int", fcol_b, 0);
    check("b_fetch_valid_int", fv_b, 1);
    wait_pos_b(5, 11, "b_pos_5_11");
    check("b_fetch_row_vact", frow_b, 6);
    check("b_fetch_valid_vact", fv_b, 0);
    wait_pos_b(6, 0, "b_pos_6_0");
    check("b_vblank_start", vbs_b, 1);
    check("b_vblank_line_start", ls_b, 1);
    check("b_vblank_blank", blank_b, 1);
    wait_pos_b(9, 11, "b_pos_9_11");
    check("b_fetch_row_wrap", frow_b, 0);
    check("b_fetch_col_wrap", fcol_b, 0);
    check("b_fetch_valid_wrap", fv_b, 1);

    wait_fs_b(per);
    wait_fs_b(per);
    check("b_frame_period", per, 450);

    // Drop en mid-frame for five cycles.
    wait_pos_b(3, 5, "b_pos_3_5");
    @(posedge clk);
    #1 en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_hold_blank", blank_b, 1);
      check("b_hold_fs", fs_b, 0);
      if (i > 0) check("b_hold_origin", {row_b, col_b}, 0);
      @(posedge clk);
    end
    #1 en_b = 1'b1;
    @(negedge clk);
    check("b_reen_fs", fs_b, 1);
    check("b_reen_row", row_b, 0);
    check("b_reen_col", col_b, 0);

    // Asynchronous reset between clock edges.
    wait_pos_b(1, 4, "b_pos_1_4");
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("b_arst_row", row_b, 0);
    check("b_arst_col", col_b, 0);
    check("b_arst_blank", blank_b, 1);
    check("b_arst_hs", hs_b, 1);
    check("b_arst_vs", vs_b, 0);
    check("b_arst_fcol", fcol_b, 4);
    check("b_arst_fvalid", fv_b, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    check("b_arst_restart_fs", fs_b, 1);

    // Random en drops and asynchronous resets; the scoreboard checks every cycle.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      r = $urandom_range(0, 999);
      if (r < 2) begin
        len = $urandom_range(1, 6);
        en_b = 1'b0;
        repeat (len) @(posedge clk);
        #1 en_b = 1'b1;
      end else if (r == 2) begin
        #2 rst_b = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
      end
    end
    b_done = 1;
  end

  // ---------------- main sequence: instances A and C ----------------
  int hs_lo_a, hs_first_a, blank_col_a, hs_hi_c, ls_gap_c, pt_low_c;

  initial begin : main
    int n;
    rst_a = 1'b0;
    en_a  = 1'b0;
    rst_c = 1'b0;
    en_c  = 1'b0;
    repeat (3) @(negedge clk);
    check("a_rst_hs", hs_a, 1);
    check("a_rst_vs", vs_a, 1);
    check("a_rst_blank", blank_a, 1);
    check("a_rst_row", row_a, 0);
    check("a_rst_col", col_a, 0);
    check("a_rst_fcol", fcol_a, 0);
    check("c_rst_fcol", fcol_c, 4);
    @(posedge clk);
    #1 rst_a = 1'b1;
    rst_c = 1'b1;
    @(posedge clk);
    #1 en_a = 1'b1;
    en_c = 1'b1;
    @(negedge clk);
    check("a_first_fs", fs_a, 1);
    check("a_first_ls", ls_a, 1);
    check("a_first_blank", blank_a, 0);

    hs_lo_a = 0; hs_first_a = -1; blank_col_a = -1;
    hs_hi_c = 0; ls_gap_c = -1; pt_low_c = 0;
    for (int k = 0; k < 8000; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 1600 && !hs_a) begin
        if (hs_first_a < 0) hs_first_a = k;
        hs_lo_a++;
      end
      if (k < 1600 && blank_a && blank_col_a < 0) blank_col_a = int'(col_a);
      if (k < 800 && hs_c) hs_hi_c++;
      if (!pt_c) pt_low_c++;
      if (k > 0 && ls_c && ls_gap_c < 0) ls_gap_c = k;
      if (k == 7996) begin
        check("c_pos_row", row_c, 9);
        check("c_pos_col", col_c, 796);
        check("c_fetch_row", frow_c, 10);
        check("c_fetch_col", fcol_c, 0);
        check("c_fetch_valid", fv_c, 1);
      end
    end
    check("a_hs_first_cycle", hs_first_a, 1312);
    check("a_hs_low_cycles", hs_lo_a, 192);
    check("a_blank_first_col", blank_col_a, 640);
    check("c_hs_high_cycles", hs_hi_c, 96);
    check("c_line_period", ls_gap_c, 800);
    check("c_pix_tick_low", pt_low_c, 0);

    n = 0;
    while (!b_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) check("b_done_timeout", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
